// File: rtl/spi_pkg.sv
// Shared SPI definitions: FSM state encodings and default word/clock settings,
// used by both the ADC read and DAC write controllers.
package spi_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SETUP  = 3'd1,
        SCK_HI = 3'd2,
        SCK_LO = 3'd3,
        HOLD   = 3'd4,
        DONE   = 3'd5
    } spi_state_e;

    localparam int SPI_NBITS_DEF = 12;
    localparam int SPI_DIV_DEF   = 4;

    // States in which the phase timer runs and chip select is asserted.
    function automatic logic is_timed(input spi_state_e s);
        return (s == SETUP) || (s == SCK_HI) || (s == SCK_LO) || (s == HOLD);
    endfunction

endpackage

// File: rtl/spi_tick_gen.sv
// Phase timer: counts 0..DIV-1 while enabled and flags the last cycle of a phase.
module spi_tick_gen #(
    parameter int DIV = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int CW = (DIV > 2) ? $clog2(DIV) : 1;

    logic [CW-1:0] cnt;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt <= '0;
        end else if (clr || !en) begin
            cnt <= '0;
        end else if (cnt == CW'(DIV - 1)) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    assign tick = en && (cnt == CW'(DIV - 1));

endmodule

// File: rtl/spi_adc_reader.sv
// SPI master that reads one NBITS-wide word (MSB first) from an ADC per request.
// Handshake: strr_i is a level request sampled only in IDLE; dv_o pulses for one cycle when data_o updates.
module spi_adc_reader
    import spi_pkg::*;
#(
    parameter int NBITS = SPI_NBITS_DEF,
    parameter int DIV   = SPI_DIV_DEF
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             strr_i,
    input  logic             miso_i,
    output logic             cs_o,
    output logic             sck_o,
    output logic [NBITS-1:0] data_o,
    output logic             dv_o,
    output logic             eor_o
);

    localparam int BW = $clog2(NBITS + 1);

    spi_state_e       state;
    spi_state_e       next_state;
    logic             tick;
    logic             timed;
    logic [NBITS-1:0] shreg;
    logic [BW-1:0]    bit_cnt;
    logic             cs_n;
    logic             sck_n;
    logic             dv_n;
    logic             eor_n;
    logic             enter_hi;
    logic             enter_done;

    assign timed      = is_timed(state);
    assign enter_hi   = (next_state == SCK_HI) && (state != SCK_HI);
    assign enter_done = (next_state == DONE) && (state != DONE);

    spi_tick_gen #(.DIV(DIV)) u_tick (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .clr   (next_state != state),
        .en    (timed),
        .tick  (tick)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:   if (strr_i) next_state = SETUP;
            SETUP:  if (tick) next_state = SCK_HI;
            SCK_HI: if (tick) next_state = (bit_cnt == BW'(NBITS)) ? HOLD : SCK_LO;
            SCK_LO: if (tick) next_state = SCK_HI;
            HOLD:   if (tick) next_state = DONE;
            DONE:   next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Outputs are decoded from the upcoming state and registered, so every pin is a flop.
    always_comb begin
        cs_n  = 1'b1;
        sck_n = 1'b0;
        dv_n  = 1'b0;
        eor_n = 1'b0;
        case (next_state)
            IDLE:                 eor_n = 1'b1;
            SETUP, SCK_LO, HOLD:  cs_n  = 1'b0;
            SCK_HI: begin
                cs_n  = 1'b0;
                sck_n = 1'b1;
            end
            DONE:                 dv_n  = 1'b1;
            default:              eor_n = 1'b1;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cs_o    <= 1'b1;
            sck_o   <= 1'b0;
            dv_o    <= 1'b0;
            eor_o   <= 1'b1;
            data_o  <= '0;
            shreg   <= '0;
            bit_cnt <= '0;
        end else begin
            cs_o  <= cs_n;
            sck_o <= sck_n;
            dv_o  <= dv_n;
            eor_o <= eor_n;
            if (state == IDLE) begin
                bit_cnt <= '0;
            end else if (enter_hi) begin
                shreg   <= {shreg[NBITS-2:0], miso_i};
                bit_cnt <= bit_cnt + BW'(1);
            end
            if (enter_done) begin
                data_o <= shreg;
            end
        end
    end

endmodule

// File: tb/tb_spi_adc_reader.sv
// Self-checking bench for spi_adc_reader: default 12-bit/DIV=4 instance plus a 16-bit/DIV=2 instance.
module tb_spi_adc_reader;

    localparam int NB   = 12;
    localparam int DV   = 4;
    localparam int NB2  = 16;
    localparam int DV2  = 2;

    // Reference timing: SETUP + NBITS high phases + (NBITS-1) low phases + HOLD, each DIV cycles.
    function automatic int model_latency(input int nbits, input int div);
        return div * (2 * nbits + 1);
    endfunction

    localparam int LAT  = DV * (2 * NB + 1);
    localparam int LAT2 = DV2 * (2 * NB2 + 1);

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- DUT instances ----------------
    logic           strr, miso, cs, sck, dv, eor;
    logic [NB-1:0]  data;
    logic           strr2, miso2, cs2, sck2, dv2, eor2;
    logic [NB2-1:0] data2;

    spi_adc_reader dut (
        .clk_i(clk), .rst_i(rst), .strr_i(strr), .miso_i(miso),
        .cs_o(cs), .sck_o(sck), .data_o(data), .dv_o(dv), .eor_o(eor)
    );

    spi_adc_reader #(.NBITS(NB2), .DIV(DV2)) dut16 (
        .clk_i(clk), .rst_i(rst), .strr_i(strr2), .miso_i(miso2),
        .cs_o(cs2), .sck_o(sck2), .data_o(data2), .dv_o(dv2), .eor_o(eor2)
    );

    // ---------------- ADC slave models ----------------
    logic [NB-1:0]  adc_word;
    logic [NB2-1:0] adc2_word;
    int adc_idx, adc2_idx;

    initial begin
        miso  = 1'b0;
        miso2 = 1'b0;
    end

    always @(negedge cs) begin
        adc_idx = NB - 1;
        miso = adc_word[adc_idx];
    end
    always @(negedge sck) if (!cs && adc_idx > 0) begin
        adc_idx = adc_idx - 1;
        miso = adc_word[adc_idx];
    end
    always @(negedge cs2) begin
        adc2_idx = NB2 - 1;
        miso2 = adc2_word[adc2_idx];
    end
    always @(negedge sck2) if (!cs2 && adc2_idx > 0) begin
        adc2_idx = adc2_idx - 1;
        miso2 = adc2_word[adc2_idx];
    end

    int rises2 = 0;
    always @(posedge sck2) rises2 = rises2 + 1;

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_fail   = 0;
    logic [NB-1:0] exp_q[$];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
                     name, act, act, exp, exp, cyc);
        end
    endtask

    logic cs_p = 1'b1, sck_p = 1'b0, dv_p = 1'b0;
    logic [NB-1:0] data_p = '0;
    int cs_fall_c, hi_c, last_fall_c, rises, dv_count = 0, last_dv_c, data_moves = 0;

    always @(negedge clk) begin
        if (!rst) begin
            if (cs_p && !cs) begin
                cs_fall_c = cyc;
                rises = 0;
            end
            if (!sck_p && sck) begin
                if (rises == 0) check("first_sck_rise_gap", cyc - cs_fall_c, DV);
                rises++;
                hi_c = cyc;
            end
            if (sck_p && !sck) begin
                check("sck_high_len", cyc - hi_c, DV);
                last_fall_c = cyc;
            end
            if (!cs_p && cs) begin
                check("cs_low_len", cyc - cs_fall_c, LAT);
                check("last_fall_to_cs_rise", cyc - last_fall_c, DV);
                check("sck_rises", rises, NB);
            end
            if (dv) begin
                dv_count++;
                last_dv_c = cyc;
                check("dv_width", int'(dv_p), 0);
                if (exp_q.size() == 0) check("dv_unexpected", 1, 0);
                else check("data", int'(data), int'(exp_q.pop_front()));
            end
            if (!dv && data !== data_p) data_moves++;
        end
        cs_p   = cs;
        sck_p  = sck;
        dv_p   = dv;
        data_p = data;
    end

    // ---------------- driver tasks ----------------
    task automatic start_read(input logic [NB-1:0] w, output int start_c);
        @(negedge clk);
        adc_word = w;
        exp_q.push_back(w);
        strr = 1'b1;
        start_c = cyc + 1;
        @(negedge clk);
        strr = 1'b0;
    endtask

    task automatic wait_dv(input int budget, output int dv_c);
        int base;
        bit ok;
        base = dv_count;
        ok = 1'b0;
        dv_c = -1;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge clk);
            #1;
            if (dv_count != base) begin
                ok = 1'b1;
                dv_c = last_dv_c;
            end
        end
        if (!ok) check("dv_timeout", 0, 1);
    endtask

    task automatic read_and_check(input logic [NB-1:0] w);
        int s, d;
        start_read(w, s);
        #1;
        check("eor_busy", int'(eor), 0);
        wait_dv(LAT + 20, d);
        check("latency", d - s, model_latency(NB, DV));
        @(negedge clk);
        #1;
        check("eor_idle", int'(eor), 1);
    endtask

    task automatic run16(input logic [NB2-1:0] w);
        int s, r0;
        bit ok;
        @(negedge clk);
        adc2_word = w;
        strr2 = 1'b1;
        s = cyc + 1;
        @(negedge clk);
        strr2 = 1'b0;
        r0 = rises2;
        ok = 1'b0;
        for (int i = 0; i < LAT2 + 20 && !ok; i++) begin
            @(negedge clk);
            #1;
            if (dv2) begin
                ok = 1'b1;
                check("w16_latency", cyc - s, model_latency(NB2, DV2));
                check("w16_data", int'(data2), int'(w));
                check("w16_sck_rises", rises2 - r0, NB2);
            end
        end
        if (!ok) check("w16_dv_timeout", 0, 1);
        @(negedge clk);
        #1;
        check("w16_dv_width", int'(dv2), 0);
    endtask

    // ---------------- vectors ----------------
    typedef struct {
        logic [NB-1:0] word;
        string         name;
    } vec_t;

    vec_t vecs[5];

    // ---------------- main sequence ----------------
    initial begin
        int s, d, d1, d2, n, base, cs_hi_bad, dv_before;
        vecs[0] = '{12'hA5C, "a5c"};
        vecs[1] = '{12'hFFF, "fff"};
        vecs[2] = '{12'h000, "zero"};
        vecs[3] = '{12'h801, "ends"};
        vecs[4] = '{12'h3C5, "mixed"};

        rst = 1'b1; strr = 1'b0; strr2 = 1'b0;
        adc_word = '0; adc2_word = '0;
        repeat (3) @(negedge clk);
        check("rst_cs", int'(cs), 1);
        check("rst_sck", int'(sck), 0);
        check("rst_dv", int'(dv), 0);
        check("rst_eor", int'(eor), 1);
        check("rst_data", int'(data), 0);
        check("rst_cs16", int'(cs2), 1);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 5; i++) read_and_check(vecs[i].word);

        for (int i = 0; i < 6; i++) begin
            repeat ($urandom_range(0, 4)) @(negedge clk);
            read_and_check(NB'($urandom_range(0, (1 << NB) - 1)));
        end

        // A second request in the middle of a transfer must be ignored.
        start_read(12'h5A3, s);
        repeat (49) @(negedge clk);
        strr = 1'b1;
        @(negedge clk);
        strr = 1'b0;
        wait_dv(LAT, d);
        check("midreq_latency", d - s, LAT);
        cs_hi_bad = 0;
        repeat (20) begin
            @(negedge clk);
            #1;
            if (!cs) cs_hi_bad++;
        end
        check("midreq_no_restart", cs_hi_bad, 0);

        // Request held high: back-to-back reads separated by the DONE cycle and one IDLE cycle.
        @(negedge clk);
        adc_word = 12'hFFF;
        exp_q.push_back(12'hFFF);
        exp_q.push_back(12'h000);
        exp_q.push_back(12'h000);
        strr = 1'b1;
        s = cyc + 1;
        n = 0; d1 = 0; d2 = 0;
        base = dv_count;
        for (int i = 0; i < 250; i++) begin
            @(negedge clk);
            #1;
            if (dv_count != base) begin
                base = dv_count;
                n++;
                if (n == 1) begin
                    d1 = last_dv_c;
                    adc_word = 12'h000;
                end else if (n == 2) begin
                    d2 = last_dv_c;
                end
            end
        end
        strr = 1'b0;
        check("b2b_pulses", n, 2);
        check("b2b_first_latency", d1 - s, LAT);
        check("b2b_gap", d2 - d1, LAT + 2);
        wait_dv(LAT + 20, d);
        repeat (3) @(negedge clk);

        // Reset in the middle of a transfer aborts it without a dv pulse.
        start_read(12'h123, s);
        repeat (39) @(negedge clk);
        dv_before = dv_count;
        rst = 1'b1;
        #1;
        check("abort_cs", int'(cs), 1);
        check("abort_sck", int'(sck), 0);
        check("abort_data", int'(data), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        repeat (5) @(negedge clk);
        check("abort_no_dv", dv_count - dv_before, 0);
        read_and_check(12'h9B6);

        run16(16'h8001);
        run16(NB2'($urandom_range(0, 65535)));
        run16(NB2'($urandom_range(0, 65535)));

        check("data_hold", data_moves, 0);
        check("queue_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
